// File: rtl/alu_cmd_issue.sv
// Command FIFO and issue stage in front of the ALU: buffers producer commands
// and hands the head entry to the ALU, one per cycle with ALU_RDY high.
module alu_cmd_issue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      FLUSH,
    input  logic                      IN_VLD,
    output logic                      IN_RDY,
    input  logic [3:0]                IN_OP,
    input  logic [1:0]                IN_MOVI,
    input  logic [DATA_WIDTH-1:0]     IN_REG_A,
    input  logic [DATA_WIDTH-1:0]     IN_REG_B,
    input  logic [DATA_WIDTH-1:0]     IN_MEM,
    input  logic [DATA_WIDTH-1:0]     IN_IMM,
    input  logic                      ALU_RDY,
    output logic                      ACT,
    output logic [3:0]                OP,
    output logic [1:0]                MOVI,
    output logic [DATA_WIDTH-1:0]     REG_A,
    output logic [DATA_WIDTH-1:0]     REG_B,
    output logic [DATA_WIDTH-1:0]     MEM,
    output logic [DATA_WIDTH-1:0]     IMM,
    output logic [$clog2(DEPTH):0]    COUNT,
    output logic                      OVF,
    output logic [15:0]               ISSUED
);

    // Handshake: a command transfers in on an edge where IN_VLD and IN_RDY are
    // both high; it transfers out on an edge where ACT is high. ACT never
    // depends on IN_VLD, and IN_RDY never depends on ALU_RDY.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]            op;
        logic [1:0]            movi;
        logic [DATA_WIDTH-1:0] reg_a;
        logic [DATA_WIDTH-1:0] reg_b;
        logic [DATA_WIDTH-1:0] mem;
        logic [DATA_WIDTH-1:0] imm;
    } cmd_t;

    cmd_t          entry_q [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   issued_q, issued_d;
    logic          push;
    logic          pop;
    logic          empty;

    assign empty  = (count_q == '0);
    assign IN_RDY = (count_q != CW'(DEPTH));
    // FLUSH wins over both transfers in its cycle.
    assign push   = IN_VLD & IN_RDY & ~FLUSH;
    assign pop    = ~empty & ALU_RDY & ~FLUSH;
    assign ACT    = pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (IN_VLD & ~IN_RDY);
        issued_d = issued_q;
        if (pop) begin
            issued_d = issued_q + 16'd1;
        end
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            issued_q <= issued_d;
        end
    end

    // Storage needs no reset: it is only observed when count_q covers it.
    always_ff @(posedge CLK) begin
        if (push) begin
            entry_q[wr_ptr_q] <= '{op: IN_OP, movi: IN_MOVI, reg_a: IN_REG_A,
                                   reg_b: IN_REG_B, mem: IN_MEM, imm: IN_IMM};
        end
    end

    always_comb begin
        head = '0;
        if (!empty) begin
            head = entry_q[rd_ptr_q];
        end
    end

    assign OP     = head.op;
    assign MOVI   = head.movi;
    assign REG_A  = head.reg_a;
    assign REG_B  = head.reg_b;
    assign MEM    = head.mem;
    assign IMM    = head.imm;
    assign COUNT  = count_q;
    assign OVF    = ovf_q;
    assign ISSUED = issued_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue: inputs change 1ns after the rising edge,
// outputs are checked a further 1ns later, well clear of the next edge.
module tb_alu_cmd_issue;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_vld;
    logic          in_rdy;
    logic [3:0]    in_op;
    logic [1:0]    in_movi;
    logic [DW-1:0] in_reg_a, in_reg_b, in_mem, in_imm;
    logic          alu_rdy;
    logic          act;
    logic [3:0]    op;
    logic [1:0]    movi;
    logic [DW-1:0] reg_a, reg_b, mem, imm;
    logic [2:0]    count;
    logic          ovf;
    logic [15:0]   issued;

    int total = 0;
    int bad   = 0;

    alu_cmd_issue #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .CLK(clk), .RST(rst_n), .FLUSH(flush),
        .IN_VLD(in_vld), .IN_RDY(in_rdy), .IN_OP(in_op), .IN_MOVI(in_movi),
        .IN_REG_A(in_reg_a), .IN_REG_B(in_reg_b), .IN_MEM(in_mem), .IN_IMM(in_imm),
        .ALU_RDY(alu_rdy), .ACT(act), .OP(op), .MOVI(movi),
        .REG_A(reg_a), .REG_B(reg_b), .MEM(mem), .IMM(imm),
        .COUNT(count), .OVF(ovf), .ISSUED(issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [3:0] o, input logic [1:0] m, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] me, input logic [7:0] im);
        in_op    = o;
        in_movi  = m;
        in_reg_a = a;
        in_reg_b = b;
        in_mem   = me;
        in_imm   = im;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        alu_rdy = 1'b0;
        set_cmd(4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_in_rdy", 32'(in_rdy), 1);
        check("rst_act", 32'(act), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_issued", 32'(issued), 0);
        check("rst_op", 32'(op), 0);
        rst_n = 1'b1;

        // single command, first-issue latency
        tick();
        in_vld  = 1'b1;
        alu_rdy = 1'b1;
        set_cmd(4'h3, 2'd2, 8'h15, 8'h00, 8'h00, 8'h07);
        #1;
        check("t1_act_push_cycle", 32'(act), 0);
        tick();
        in_vld = 1'b0;
        #1;
        check("t1_act", 32'(act), 1);
        check("t1_op", 32'(op), 32'h3);
        check("t1_movi", 32'(movi), 2);
        check("t1_reg_a", 32'(reg_a), 32'h15);
        check("t1_imm", 32'(imm), 32'h07);
        check("t1_count_before", 32'(count), 1);
        tick();
        #1;
        check("t1_act_after", 32'(act), 0);
        check("t1_issued", 32'(issued), 1);
        check("t1_count", 32'(count), 0);
        check("t1_op_empty", 32'(op), 0);

        // fill to full, fifth push rejected
        alu_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1;
            set_cmd(4'(i + 1), 2'(i), 8'(8'h20 + i), 8'h00, 8'h00, 8'h00);
            #1;
            check("t2_in_rdy", 32'(in_rdy), (i < 4) ? 1 : 0);
            check("t2_ovf_pre", 32'(ovf), 0);
            tick();
        end
        in_vld = 1'b0;
        #1;
        check("t2_count_full", 32'(count), 4);
        check("t2_ovf", 32'(ovf), 1);
        check("t2_head_op", 32'(op), 1);
        alu_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_drain_act", 32'(act), 1);
            check("t2_drain_op", 32'(op), 32'(k + 1));
            check("t2_drain_movi", 32'(movi), 32'(k));
            check("t2_drain_reg_a", 32'(reg_a), 32'(8'h20 + k));
            tick();
        end
        #1;
        check("t2_count_empty", 32'(count), 0);
        check("t2_act_empty", 32'(act), 0);
        check("t2_issued", 32'(issued), 5);

        // continuous streaming, 20 commands through a wrapping FIFO
        for (int j = 0; j <= 20; j++) begin
            if (j < 20) begin
                in_vld = 1'b1;
                set_cmd(4'h7, 2'd0, 8'(j), 8'h00, 8'h00, 8'h00);
            end else begin
                in_vld = 1'b0;
            end
            #1;
            if (j == 0) begin
                check("t3_act_first", 32'(act), 0);
            end else begin
                check("t3_act", 32'(act), 1);
                check("t3_reg_a", 32'(reg_a), 32'(j - 1));
                check("t3_count", 32'(count), 1);
            end
            tick();
        end
        #1;
        check("t3_count_end", 32'(count), 0);
        check("t3_issued", 32'(issued), 25);

        // ALU_RDY toggling with three entries buffered
        alu_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1;
            set_cmd(4'(4'hA + i), 2'd1, 8'(8'h40 + i), 8'h55, 8'h66, 8'h77);
            tick();
        end
        in_vld  = 1'b0;
        alu_rdy = 1'b1;
        #1;
        check("t4_c0_act", 32'(act), 1);
        check("t4_c0_op", 32'(op), 32'hA);
        check("t4_c0_count", 32'(count), 3);
        tick();
        alu_rdy = 1'b0;
        #1;
        check("t4_c1_act", 32'(act), 0);
        check("t4_c1_op", 32'(op), 32'hB);
        check("t4_c1_reg_a", 32'(reg_a), 32'h41);
        check("t4_c1_count", 32'(count), 2);
        tick();
        alu_rdy = 1'b1;
        #1;
        check("t4_c2_act", 32'(act), 1);
        check("t4_c2_op_held", 32'(op), 32'hB);
        check("t4_c2_mem", 32'(mem), 32'h66);
        check("t4_c2_count", 32'(count), 2);
        tick();
        alu_rdy = 1'b0;
        #1;
        check("t4_c3_act", 32'(act), 0);
        check("t4_c3_op", 32'(op), 32'hC);
        check("t4_c3_count", 32'(count), 1);
        check("t4_issued", 32'(issued), 27);

        // flush with three entries and a push in the same cycle
        for (int i = 0; i < 2; i++) begin
            in_vld = 1'b1;
            set_cmd(4'(4'hD + i), 2'd3, 8'h50, 8'h00, 8'h00, 8'h00);
            tick();
        end
        in_vld = 1'b0;
        #1;
        check("t5_count_pre", 32'(count), 3);
        flush   = 1'b1;
        in_vld  = 1'b1;
        alu_rdy = 1'b1;
        set_cmd(4'hF, 2'd0, 8'hEE, 8'h00, 8'h00, 8'h00);
        #1;
        check("t5_act_in_flush", 32'(act), 0);
        tick();
        flush  = 1'b0;
        in_vld = 1'b0;
        #1;
        check("t5_count", 32'(count), 0);
        check("t5_act", 32'(act), 0);
        check("t5_op", 32'(op), 0);
        check("t5_issued", 32'(issued), 27);
        check("t5_ovf", 32'(ovf), 1);
        check("t5_in_rdy", 32'(in_rdy), 1);

        // asynchronous reset mid-stream
        alu_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_vld = 1'b1;
            set_cmd(4'h9, 2'd0, 8'(8'h60 + i), 8'h00, 8'h00, 8'h00);
            tick();
        end
        in_vld = 1'b0;
        #1;
        check("t6_count_pre", 32'(count), 2);
        alu_rdy = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_count", 32'(count), 0);
        check("t6_ovf", 32'(ovf), 0);
        check("t6_issued", 32'(issued), 0);
        check("t6_act", 32'(act), 0);
        check("t6_in_rdy", 32'(in_rdy), 1);
        check("t6_op", 32'(op), 0);
        rst_n = 1'b1;
        tick();
        in_vld = 1'b1;
        set_cmd(4'h5, 2'd0, 8'h33, 8'h00, 8'h00, 8'h00);
        tick();
        in_vld = 1'b0;
        #1;
        check("t6_recover_act", 32'(act), 1);
        check("t6_recover_op", 32'(op), 32'h5);
        tick();
        #1;
        check("t6_recover_issued", 32'(issued), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
